// File: rtl/harv_dmem_wb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : harv_dmem_if / harv_wb_if
// Purpose : Bundles for the harv data-memory req/gnt port and for the
//           Wishbone-classic data_mem bus. The bridge uses dmem.slave and
//           wb.master; the core and the memory use the opposite modports.
// Revision: 1.0  initial release
// ============================================================================

// harv core data-memory request/grant port
interface harv_dmem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  dmem_req_i;
    logic                  dmem_wren_i;
    logic [1:0]            dmem_ben_i;
    logic                  dmem_usgn_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [31:0]           dmem_wdata_i;
    logic                  dmem_gnt_o;
    logic                  dmem_err_o;
    logic [31:0]           dmem_rdata_o;

    // Core side: issues requests, receives completion
    modport master (
        output dmem_req_i,
        output dmem_wren_i,
        output dmem_ben_i,
        output dmem_usgn_i,
        output dmem_addr_i,
        output dmem_wdata_i,
        input  dmem_gnt_o,
        input  dmem_err_o,
        input  dmem_rdata_o
    );

    // Bridge side: accepts requests, returns completion
    modport slave (
        input  dmem_req_i,
        input  dmem_wren_i,
        input  dmem_ben_i,
        input  dmem_usgn_i,
        input  dmem_addr_i,
        input  dmem_wdata_i,
        output dmem_gnt_o,
        output dmem_err_o,
        output dmem_rdata_o
    );
endinterface

// Wishbone-classic data memory bus
interface harv_wb_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [3:0]            wb_sel_o;
    logic [ADDR_WIDTH-1:0] wb_addr_o;
    logic [31:0]           wb_data_o;
    logic [31:0]           wb_data_i;
    logic                  wb_ack_i;

    // Bus master (the bridge)
    modport master (
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_sel_o,
        output wb_addr_o,
        output wb_data_o,
        input  wb_data_i,
        input  wb_ack_i
    );

    // Bus slave (the memory controller)
    modport slave (
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_sel_o,
        input  wb_addr_o,
        input  wb_data_o,
        output wb_data_i,
        output wb_ack_i
    );
endinterface

`default_nettype wire

// File: rtl/harv_dmem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module  : harv_dmem_wb_bridge
// Purpose : Converts the harv core data-memory req/gnt port into a
//           Wishbone-classic master. Registers each request, builds byte
//           lanes and replicated write data, extracts and extends load data,
//           and flags misaligned accesses (and optionally bus timeouts).
// Options : HARV_DMEM_BRIDGE_TIMEOUT_EN - when defined, a BUS-state cycle
//           counter aborts a transfer after TIMEOUT_CYCLES cycles without ack.
// Revision: 1.0  initial release
// ============================================================================
module harv_dmem_wb_bridge #(
    parameter int ADDR_WIDTH = 32
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  wire logic  clk,
    input  wire logic  rst,
    harv_dmem_if.slave dmem,
    harv_wb_if.master  wb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q;

    // Bus-facing registers
    logic                  cyc_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    // Captured request attributes needed to shape the load result
    logic [1:0]            size_q;
    logic                  usgn_q;
    logic [1:0]            addr_lo_q;

    // Core-facing registers
    logic                  gnt_q;
    logic                  err_q;
    logic [31:0]           rdata_q;

    // Request decode (from live core inputs) and load shaping (from bus data)
    logic                  misalign_d;
    logic [3:0]            sel_d;
    logic [31:0]           wdata_d;
    logic [7:0]            byte_d;
    logic [15:0]           half_d;
    logic [31:0]           rdata_d;

`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]      cnt_q;
`endif

    // Decode size into lane select, replicated store data and alignment check
    always_comb begin
        misalign_d = 1'b0;
        sel_d      = 4'b1111;
        wdata_d    = dmem.dmem_wdata_i;
        case (dmem.dmem_ben_i)
            2'b00: begin
                sel_d   = 4'b0001 << dmem.dmem_addr_i[1:0];
                wdata_d = {4{dmem.dmem_wdata_i[7:0]}};
            end
            2'b01: begin
                misalign_d = dmem.dmem_addr_i[0];
                sel_d      = dmem.dmem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{dmem.dmem_wdata_i[15:0]}};
            end
            default: begin
                misalign_d = (dmem.dmem_addr_i[1:0] != 2'b00);
            end
        endcase
    end

    // Pick the addressed lane of the bus read data and extend it to 32 bits
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_d = wb.wb_data_i[7:0];
            2'd1:    byte_d = wb.wb_data_i[15:8];
            2'd2:    byte_d = wb.wb_data_i[23:16];
            default: byte_d = wb.wb_data_i[31:24];
        endcase
        half_d = addr_lo_q[1] ? wb.wb_data_i[31:16] : wb.wb_data_i[15:0];
        case (size_q)
            2'b00:   rdata_d = usgn_q ? {24'd0, byte_d} : {{24{byte_d[7]}}, byte_d};
            2'b01:   rdata_d = usgn_q ? {16'd0, half_d} : {{16{half_d[15]}}, half_d};
            default: rdata_d = wb.wb_data_i;
        endcase
    end

    // Transfer FSM: IDLE -> BUS -> RESP -> IDLE, with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            size_q    <= 2'd0;
            usgn_q    <= 1'b0;
            addr_lo_q <= 2'd0;
            gnt_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dmem.dmem_req_i) begin
                        if (misalign_d) begin
                            // Misaligned: no bus cycle, complete with error
                            state_q <= S_RESP;
                            gnt_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else begin
                            state_q   <= S_BUS;
                            cyc_q     <= 1'b1;
                            we_q      <= dmem.dmem_wren_i;
                            sel_q     <= sel_d;
                            addr_q    <= {dmem.dmem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            wdata_q   <= wdata_d;
                            size_q    <= dmem.dmem_ben_i;
                            usgn_q    <= dmem.dmem_usgn_i;
                            addr_lo_q <= dmem.dmem_addr_i[1:0];
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end
                    end
                end

                S_BUS: begin
                    if (wb.wb_ack_i) begin
                        // Ack beats a timeout that expires in the same cycle
                        state_q <= S_RESP;
                        cyc_q   <= 1'b0;
                        gnt_q   <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? 32'd0 : rdata_d;
                    end
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        state_q <= S_RESP;
                        cyc_q   <= 1'b0;
                        gnt_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    // Grant lasts exactly this one cycle
                    state_q <= S_IDLE;
                    gnt_q   <= 1'b0;
                    err_q   <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    gnt_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wb.wb_cyc_o       = cyc_q;
    assign wb.wb_stb_o       = cyc_q;
    assign wb.wb_we_o        = we_q;
    assign wb.wb_sel_o       = sel_q;
    assign wb.wb_addr_o      = addr_q;
    assign wb.wb_data_o      = wdata_q;

    assign dmem.dmem_gnt_o   = gnt_q;
    assign dmem.dmem_err_o   = err_q;
    assign dmem.dmem_rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_harv_dmem_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_harv_dmem_wb_bridge
// Purpose : Self-checking bench for harv_dmem_wb_bridge. Directed scenarios
//           plus randomized accesses checked against a byte-level model.
//           Define HARV_DMEM_BRIDGE_TIMEOUT_EN to also exercise the timeout.
// Revision: 1.0  initial release
// ============================================================================
module tb_harv_dmem_wb_bridge;

`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
    localparam int TB_TO = 4;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    harv_dmem_if #(.ADDR_WIDTH(32)) dmem_if ();
    harv_wb_if   #(.ADDR_WIDTH(32)) wb_if ();

    harv_dmem_wb_bridge #(
        .ADDR_WIDTH(32)
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TB_TO)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dmem (dmem_if),
        .wb   (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One core access with a Wishbone slave answering after 'waits' wait-states
    // (waits < 0: never acknowledge). Expectations come from a byte-level model.
    task automatic do_access(input logic wren, input logic [1:0] ben, input logic usgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] bdata, input int waits, input string tag,
                             output logic [31:0] obs_rdata, output logic obs_err,
                             output logic [3:0] obs_sel, output int obs_lat);
        int          nbytes, a, off, exp_lat, exp_bus, bus_n;
        logic        mis, tmo, exp_err, got;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wd, exp_rd, mask, exp_addr;

        nbytes = (ben == 2'b00) ? 1 : (ben == 2'b01) ? 2 : 4;
        a      = int'(addr[1:0]);
        mis    = (a % nbytes) != 0;
        off    = a - (a % nbytes);
        exp_sel  = 4'(((1 << nbytes) - 1) << off);
        exp_addr = addr & ~32'h3;
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        exp_rd = (bdata >> (8 * off)) & mask;
        if (!usgn && nbytes < 4 && exp_rd[8*nbytes-1]) exp_rd = exp_rd | ~mask;
        if (wren) exp_rd = 32'd0;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
        tmo = !mis && (waits < 0 || waits >= TB_TO);
`else
        tmo = 1'b0;
`endif
        if (tmo) exp_rd = 32'd0;
        exp_err = mis || tmo;
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
        exp_lat = mis ? 2 : tmo ? 2 + TB_TO : 3 + waits;
        exp_bus = mis ? 0 : tmo ? TB_TO : waits + 1;
`else
        exp_lat = mis ? 2 : 3 + waits;
        exp_bus = mis ? 0 : waits + 1;
`endif

        obs_rdata = 32'd0; obs_err = 1'b0; obs_sel = 4'd0; obs_lat = -1;
        got = 1'b0; bus_n = 0;

        @(negedge clk);
        dmem_if.dmem_req_i   = 1'b1;
        dmem_if.dmem_wren_i  = wren;
        dmem_if.dmem_ben_i   = ben;
        dmem_if.dmem_usgn_i  = usgn;
        dmem_if.dmem_addr_i  = addr;
        dmem_if.dmem_wdata_i = wdata;

        for (int k = 1; k <= 300 && !got; k++) begin
            if (k > 1) @(negedge clk);
            if (dmem_if.dmem_gnt_o) begin
                got = 1'b1;
                obs_lat = k; obs_err = dmem_if.dmem_err_o; obs_rdata = dmem_if.dmem_rdata_o;
                dmem_if.dmem_req_i = 1'b0;
                wb_if.wb_ack_i     = 1'b0;
                n_vec++;
                if (k !== exp_lat) begin
                    n_err++;
                    $display("FAIL %s latency: got %0d want %0d", tag, k, exp_lat);
                end
                n_vec++;
                if (dmem_if.dmem_err_o !== exp_err) begin
                    n_err++;
                    $display("FAIL %s err: got %b want %b", tag, dmem_if.dmem_err_o, exp_err);
                end
                n_vec++;
                if (wb_if.wb_cyc_o !== 1'b0 || bus_n !== exp_bus) begin
                    n_err++;
                    $display("FAIL %s bus cycles: cyc_at_gnt %b count %0d want cyc 0 count %0d",
                             tag, wb_if.wb_cyc_o, bus_n, exp_bus);
                end
                if (!mis) begin
                    n_vec++;
                    if (dmem_if.dmem_rdata_o !== exp_rd) begin
                        n_err++;
                        $display("FAIL %s rdata: got %h want %h", tag, dmem_if.dmem_rdata_o, exp_rd);
                    end
                end
            end else if (wb_if.wb_cyc_o) begin
                bus_n++;
                obs_sel = wb_if.wb_sel_o;
                n_vec++;
                if ({wb_if.wb_stb_o, wb_if.wb_we_o, wb_if.wb_sel_o, wb_if.wb_addr_o, wb_if.wb_data_o}
                    !== {1'b1, wren, exp_sel, exp_addr, exp_wd}) begin
                    n_err++;
                    $display("FAIL %s bus fields stb/we/sel/addr/data: got %b/%b/%b/%h/%h want 1/%b/%b/%h/%h",
                             tag, wb_if.wb_stb_o, wb_if.wb_we_o, wb_if.wb_sel_o, wb_if.wb_addr_o,
                             wb_if.wb_data_o, wren, exp_sel, exp_addr, exp_wd);
                end
                wb_if.wb_ack_i  = (waits >= 0) && (bus_n == waits + 1);
                wb_if.wb_data_i = wb_if.wb_ack_i ? bdata : $urandom;
            end else begin
                wb_if.wb_ack_i = 1'b0;
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            dmem_if.dmem_req_i = 1'b0;
            wb_if.wb_ack_i     = 1'b0;
            $display("FAIL %s gnt timeout: got none want gnt at cycle %0d", tag, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_if.dmem_req_i = 1'b0; dmem_if.dmem_wren_i = 1'b0; dmem_if.dmem_ben_i = 2'b00;
        dmem_if.dmem_usgn_i = 1'b0; dmem_if.dmem_addr_i = 32'd0; dmem_if.dmem_wdata_i = 32'd0;
        wb_if.wb_ack_i = 1'b0; wb_if.wb_data_i = 32'd0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({wb_if.wb_cyc_o, wb_if.wb_stb_o, wb_if.wb_we_o, wb_if.wb_sel_o} !== 7'd0) begin
            n_err++;
            $display("FAIL reset bus ctrl: got %b want 0", {wb_if.wb_cyc_o, wb_if.wb_stb_o, wb_if.wb_we_o, wb_if.wb_sel_o});
        end
        n_vec++;
        if ({wb_if.wb_addr_o, wb_if.wb_data_o} !== 64'd0) begin
            n_err++;
            $display("FAIL reset bus addr/data: got %h/%h want 0", wb_if.wb_addr_o, wb_if.wb_data_o);
        end
        n_vec++;
        if ({dmem_if.dmem_gnt_o, dmem_if.dmem_err_o, dmem_if.dmem_rdata_o} !== 34'd0) begin
            n_err++;
            $display("FAIL reset core side gnt/err/rdata: got %b/%b/%h want 0", dmem_if.dmem_gnt_o,
                     dmem_if.dmem_err_o, dmem_if.dmem_rdata_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] rd; logic er; logic [3:0] sl; int lt;
        do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw_0x100", rd, er, sl, lt);
        n_vec++;
        if ({sl, rd, er} !== {4'b1111, 32'hDEADBEEF, 1'b0} || lt !== 3) begin
            n_err++;
            $display("FAIL lw_0x100 sel/rdata/err/lat: got %b/%h/%b/%0d want 1111/deadbeef/0/3", sl, rd, er, lt);
        end
        do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, "lb_0x103", rd, er, sl, lt);
        n_vec++;
        if ({sl, rd} !== {4'b1000, 32'hFFFFFF80}) begin
            n_err++;
            $display("FAIL lb_0x103 sel/rdata: got %b/%h want 1000/ffffff80", sl, rd);
        end
        do_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80112233, 0, "lhu_0x102", rd, er, sl, lt);
        n_vec++;
        if ({sl, rd} !== {4'b1100, 32'h00008011}) begin
            n_err++;
            $display("FAIL lhu_0x102 sel/rdata: got %b/%h want 1100/00008011", sl, rd);
        end
        do_access(1'b1, 2'b01, 1'b0, 32'h206, 32'h0000ABCD, 32'h5555AAAA, 2, "sh_0x206", rd, er, sl, lt);
        n_vec++;
        if ({sl, rd, er} !== {4'b1100, 32'h0, 1'b0} || lt !== 5) begin
            n_err++;
            $display("FAIL sh_0x206 sel/rdata/err/lat: got %b/%h/%b/%0d want 1100/00000000/0/5", sl, rd, er, lt);
        end
        do_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h11111111, 0, "lw_0x101", rd, er, sl, lt);
        n_vec++;
        if (er !== 1'b1 || lt !== 2) begin
            n_err++;
            $display("FAIL lw_0x101 err/lat: got %b/%0d want 1/2", er, lt);
        end
        do_access(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0, "lw_0x104", rd, er, sl, lt);
        n_vec++;
        if ({rd, er} !== {32'h0BADF00D, 1'b0} || lt !== 3) begin
            n_err++;
            $display("FAIL lw_0x104 rdata/err/lat: got %h/%b/%0d want 0badf00d/0/3", rd, er, lt);
        end
    endtask

    task automatic test_ack_outside_bus();
        logic [31:0] rd; logic er; logic [3:0] sl; int lt;
        do_access(1'b0, 2'b10, 1'b0, 32'h180, 32'h0, 32'hCAFEF00D, 1, "lw_hold", rd, er, sl, lt);
        wb_if.wb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_if.wb_data_i = $urandom;
            n_vec++;
            if ({dmem_if.dmem_gnt_o, wb_if.wb_cyc_o} !== 2'b00 || dmem_if.dmem_rdata_o !== 32'hCAFEF00D) begin
                n_err++;
                $display("FAIL idle_ack gnt/cyc/rdata: got %b/%b/%h want 0/0/cafef00d",
                         dmem_if.dmem_gnt_o, wb_if.wb_cyc_o, dmem_if.dmem_rdata_o);
            end
        end
        wb_if.wb_ack_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; logic [3:0] sl; int lt;
        for (int i = 0; i < 6; i++)
            do_access(i[0], 2'b10, 1'b0, 32'h1000 + 32'(4 * i), $urandom, $urandom, 0, "b2b", rd, er, sl, lt);
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; logic [3:0] sl; int lt;
        logic [31:0] addr;
        for (int i = 0; i < 60; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      addr, $urandom, $urandom, $urandom_range(0, 3), "random", rd, er, sl, lt);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] rd; logic er; logic [3:0] sl; int lt;
        @(negedge clk);
        dmem_if.dmem_req_i = 1'b1; dmem_if.dmem_wren_i = 1'b0; dmem_if.dmem_ben_i = 2'b10;
        dmem_if.dmem_addr_i = 32'h300;
        @(negedge clk);
        n_vec++;
        if (wb_if.wb_cyc_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid bus start: cyc got %b want 1", wb_if.wb_cyc_o);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({wb_if.wb_cyc_o, wb_if.wb_stb_o, dmem_if.dmem_gnt_o} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid async drop cyc/stb/gnt: got %b want 000",
                     {wb_if.wb_cyc_o, wb_if.wb_stb_o, dmem_if.dmem_gnt_o});
        end
        @(negedge clk);
        rst = 1'b0;
        dmem_if.dmem_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({dmem_if.dmem_gnt_o, wb_if.wb_cyc_o} !== 2'b00) begin
                n_err++;
                $display("FAIL rst_mid stale gnt/cyc: got %b/%b want 0/0", dmem_if.dmem_gnt_o, wb_if.wb_cyc_o);
            end
        end
        do_access(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h600DCAFE, 0, "lw_after_rst", rd, er, sl, lt);
    endtask

`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd; logic er; logic [3:0] sl; int lt;
        do_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h12345678, -1, "timeout", rd, er, sl, lt);
        n_vec++;
        if ({er, rd} !== {1'b1, 32'h0} || lt !== 2 + TB_TO) begin
            n_err++;
            $display("FAIL timeout err/rdata/lat: got %b/%h/%0d want 1/00000000/%0d", er, rd, lt, 2 + TB_TO);
        end
        do_access(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h87654321, TB_TO - 1, "ack_at_expiry", rd, er, sl, lt);
        n_vec++;
        if ({er, rd} !== {1'b0, 32'h87654321}) begin
            n_err++;
            $display("FAIL ack_at_expiry err/rdata: got %b/%h want 0/87654321", er, rd);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_ack_outside_bus();
        test_back_to_back();
        test_random();
        test_reset_mid_transfer();
`ifdef HARV_DMEM_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
